serial_full_adder: RTL and testbench

Parametrised bit-serial adder/subtractor built around a single full-adder cell. It accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake, then adds or subtracts them one bit per clock, LSB first. It presents the sum, carry-out and signed-overflow flag on a held output handshake. It sits between the pmod input capture logic and the LED driver in the iCEstick top level, and is the sequential, width-generic successor to the combinational gate/adder blocks.

---
 rtl/adder_pkg.sv | 20 ++
 rtl/full_adder_cell.sv | 18 +
 rtl/serial_full_adder.sv | 161 ++++++++++++++++
 tb/tb_serial_full_adder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
//   adder_state_t       : controller states (IDLE, RUN, DONE)
//   ADDER_DEFAULT_WIDTH : default operand width
//   adder_cnt_width()   : bit counter width for a given operand width
package adder_pkg;

  localparam int ADDER_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } adder_state_t;

  // Wide enough to hold the value WIDTH itself.
  function automatic int adder_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Purely combinational 1-bit full adder.
//   a, b, ci : addend bits and carry-in
//   s, co    : sum bit and carry-out
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/serial_full_adder.sv
// Bit-serial adder/subtractor, one bit per clock, LSB first, built around a
// single full_adder_cell.
//
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   in_valid/in_ready  : operand handshake (a, b, cin, sub)
//   a, b               : WIDTH-bit operands
//   cin                : carry-in, ignored when sub=1
//   sub                : 0 -> a+b+cin, 1 -> a-b
//   out_valid/out_ready: result handshake (sum, cout, ovf)
//   sum, cout, ovf     : result, carry out of MSB, signed overflow
//   busy               : high while bits are being processed
//   dbg_state_o        : current controller state
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. The producer keeps data stable while valid is high and ready is
// low; valid does not depend on ready. out_valid stays high and sum/cout/ovf
// stay stable until the transfer completes.
module serial_full_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output adder_state_t     dbg_state_o
);

  localparam int CNT_W = adder_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  // Index of the bit just below the MSB. For WIDTH=1 this wraps to a value
  // the counter never holds in RUN, so the loaded carry stays as the
  // carry into the MSB.
  localparam logic [CNT_W-1:0] MSB_PREV = LAST_BIT - CNT_W'(1);

  adder_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic             carry_q, carry_d;
  logic             cmsb_q, cmsb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic cell_s;
  logic cell_co;

  full_adder_cell u_cell (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .ci (carry_q),
    .s  (cell_s),
    .co (cell_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cmsb_q   <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cmsb_q   <= cmsb_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cmsb_d   = cmsb_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is a + ~b + 1.
          a_sr_d   = a;
          b_sr_d   = sub ? ~b : b;
          carry_d  = sub ? 1'b1 : cin;
          cmsb_d   = sub ? 1'b1 : cin;
          sum_sr_d = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        sum_sr_d            = sum_sr_q >> 1;
        sum_sr_d[WIDTH-1]   = cell_s;
        a_sr_d              = a_sr_q >> 1;
        b_sr_d              = b_sr_q >> 1;
        carry_d             = cell_co;
        cnt_d               = cnt_q + CNT_W'(1);
        // The carry leaving the bit below the MSB is the carry into the MSB.
        if (cnt_q == MSB_PREV) begin
          cmsb_d = cell_co;
        end
        if (cnt_q == LAST_BIT) begin
          sum_d   = sum_sr_d;
          cout_d  = cell_co;
          ovf_d   = cmsb_q ^ cell_co;
          state_d = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q == RUN);
  assign out_valid   = (state_q == DONE);
  assign sum         = sum_q;
  assign cout        = cout_q;
  assign ovf         = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_full_adder.sv
module tb_serial_full_adder;
  import adder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // shared operand buses, per-instance handshake
  logic [31:0] a_drv = '0;
  logic [31:0] b_drv = '0;
  logic        cin_drv = 1'b0;
  logic        sub_drv = 1'b0;

  logic in_valid1 = 1'b0, in_valid8 = 1'b0, in_valid32 = 1'b0;
  logic out_ready1 = 1'b0, out_ready8 = 1'b0, out_ready32 = 1'b0;

  logic rdy1, ov1, busy1, cout1, ovf1;
  logic [0:0] sum1;
  adder_state_t st1;
  logic rdy8, ov8, busy8, cout8, ovf8;
  logic [7:0] sum8;
  adder_state_t st8;
  logic rdy32, ov32, busy32, cout32, ovf32;
  logic [31:0] sum32;
  adder_state_t st32;

  serial_full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(rdy1),
    .a(a_drv[0:0]), .b(b_drv[0:0]), .cin(cin_drv), .sub(sub_drv),
    .out_valid(ov1), .out_ready(out_ready1), .sum(sum1), .cout(cout1),
    .ovf(ovf1), .busy(busy1), .dbg_state_o(st1)
  );

  serial_full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(rdy8),
    .a(a_drv[7:0]), .b(b_drv[7:0]), .cin(cin_drv), .sub(sub_drv),
    .out_valid(ov8), .out_ready(out_ready8), .sum(sum8), .cout(cout8),
    .ovf(ovf8), .busy(busy8), .dbg_state_o(st8)
  );

  serial_full_adder #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(rdy32),
    .a(a_drv), .b(b_drv), .cin(cin_drv), .sub(sub_drv),
    .out_valid(ov32), .out_ready(out_ready32), .sum(sum32), .cout(cout32),
    .ovf(ovf32), .busy(busy32), .dbg_state_o(st32)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, overflow from operand/result signs.
  // Returns {ovf, cout, sum[31:0]}.
  function automatic logic [33:0] model(input int w, input logic [31:0] av, bv,
                                        input logic cv, sv);
    logic [63:0] mask, am, bm, full, s;
    logic co, ov;
    mask = (64'd1 << w) - 64'd1;
    am   = {32'd0, av} & mask;
    bm   = (sv ? ~{32'd0, bv} : {32'd0, bv}) & mask;
    full = am + bm + {63'd0, (sv ? 1'b1 : cv)};
    s    = full & mask;
    co   = full[w];
    ov   = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
    return {ov, co, s[31:0]};
  endfunction

  // {in_ready, out_valid, busy, cout, ovf}
  function automatic logic [4:0] flags(input int w);
    case (w)
      1:       return {rdy1, ov1, busy1, cout1, ovf1};
      8:       return {rdy8, ov8, busy8, cout8, ovf8};
      default: return {rdy32, ov32, busy32, cout32, ovf32};
    endcase
  endfunction

  function automatic logic [31:0] get_sum(input int w);
    case (w)
      1:       return 32'(sum1);
      8:       return 32'(sum8);
      default: return sum32;
    endcase
  endfunction

  task automatic set_valid(input int w, input logic v);
    case (w)
      1:       in_valid1 = v;
      8:       in_valid8 = v;
      default: in_valid32 = v;
    endcase
  endtask

  task automatic set_ready(input int w, input logic v);
    case (w)
      1:       out_ready1 = v;
      8:       out_ready8 = v;
      default: out_ready32 = v;
    endcase
  endtask

  // ---------------- driver tasks ----------------
  // Waits (bounded) for in_ready, presents operands for one edge.
  task automatic start_op(input int w, input logic [31:0] av, bv,
                          input logic cv, sv, input string tag);
    int k = 0;
    while (!flags(w)[4] && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_in_ready"}, 32'(flags(w)[4]), 32'd1);
    a_drv = av; b_drv = bv; cin_drv = cv; sub_drv = sv;
    set_valid(w, 1'b1);
    @(negedge clk);
    set_valid(w, 1'b0);
  endtask

  // Called at the first negedge after acceptance; checks out_valid latency.
  task automatic wait_done(input int w, input string tag);
    int k = 0;
    while (!flags(w)[3] && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"}, 32'(k), 32'(w));
  endtask

  task automatic do_op(input int w, input logic [31:0] av, bv, input logic cv, sv,
                       input logic [31:0] es, input logic ec, eo,
                       input logic b2b, input string tag);
    set_ready(w, b2b);
    start_op(w, av, bv, cv, sv, tag);
    wait_done(w, tag);
    chk({tag, "_sum"}, get_sum(w), es);
    chk({tag, "_cout"}, 32'(flags(w)[1]), 32'(ec));
    chk({tag, "_ovf"}, 32'(flags(w)[0]), 32'(eo));
    if (!b2b) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      chk({tag, "_held"}, 32'(flags(w)[3]), 32'd1);
      set_ready(w, 1'b1);
      @(negedge clk);
      set_ready(w, 1'b0);
      chk({tag, "_released"}, 32'(flags(w)[4:3]), 32'b10);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [33:0] exp;
    logic [31:0] av, bv;
    logic cv, sv;
    logic seen;

    // reset state, asserted from time 0
    #3;
    chk("rst_flags_w8", 32'(flags(8)), 32'b10000);
    chk("rst_sum_w8", get_sum(8), 32'd0);
    chk("rst_state_w8", 32'(st8), 32'(IDLE));
    chk("rst_flags_w1", 32'(flags(1)), 32'b10000);
    chk("rst_flags_w32", 32'(flags(32)), 32'b10000);
    chk("rst_sum_w32", get_sum(32), 32'd0);
    chk("rst_state_w32", 32'(st32) | 32'(st1), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // WIDTH=8 directed vectors
    do_op(8, 32'h0F, 32'h01, 1'b0, 1'b0, 32'h10, 1'b0, 1'b0, 1'b0, "add_0f_01");
    do_op(8, 32'hFF, 32'h01, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b0, "add_ff_01");
    do_op(8, 32'h7F, 32'h01, 1'b0, 1'b0, 32'h80, 1'b0, 1'b1, 1'b0, "add_7f_01");
    do_op(8, 32'h12, 32'h34, 1'b1, 1'b0, 32'h47, 1'b0, 1'b0, 1'b0, "add_cin");
    do_op(8, 32'h05, 32'h07, 1'b1, 1'b1, 32'hFE, 1'b0, 1'b0, 1'b0, "sub_05_07");
    do_op(8, 32'h80, 32'h01, 1'b0, 1'b1, 32'h7F, 1'b1, 1'b1, 1'b0, "sub_80_01");

    // backpressure: result held 5 cycles, a stray in_valid is ignored
    set_ready(8, 1'b0);
    start_op(8, 32'h01, 32'h02, 1'b0, 1'b0, "bp");
    chk("bp_busy", 32'(flags(8)[2]), 32'd1);
    wait_done(8, "bp");
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        a_drv = 32'hFF; b_drv = 32'hFF;
        in_valid8 = 1'b1;
      end
      if (i == 2) in_valid8 = 1'b0;
      @(negedge clk);
      chk("bp_out_valid", 32'(flags(8)[3]), 32'd1);
      chk("bp_in_ready", 32'(flags(8)[4]), 32'd0);
      chk("bp_sum", get_sum(8), 32'h03);
    end
    set_ready(8, 1'b1);
    @(negedge clk);
    set_ready(8, 1'b0);
    chk("bp_released", 32'(flags(8)[4:3]), 32'b10);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (ov8 || busy8) seen = 1'b1;
    end
    chk("bp_no_extra_result", 32'(seen), 32'd0);

    // reset after bit 3 of a run
    start_op(8, 32'hAA, 32'h55, 1'b0, 1'b0, "rst_run");
    repeat (4) @(negedge clk);
    chk("rst_run_busy", 32'(flags(8)[2]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_run_flags", 32'(flags(8)), 32'b10000);
    chk("rst_run_sum", get_sum(8), 32'd0);
    chk("rst_run_state", 32'(st8), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (ov8) seen = 1'b1;
    end
    chk("rst_run_no_result", 32'(seen), 32'd0);
    do_op(8, 32'h03, 32'h04, 1'b0, 1'b0, 32'h07, 1'b0, 1'b0, 1'b0, "after_rst");

    // WIDTH=1 directed
    do_op(1, 32'h1, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, "w1_1p1");

    // width sweeps: first half with pauses, second half back-to-back
    for (int i = 0; i < 100; i++) begin
      av = $urandom; bv = $urandom;
      cv = 1'($urandom_range(0, 1)); sv = 1'($urandom_range(0, 1));
      exp = model(1, av, bv, cv, sv);
      do_op(1, av, bv, cv, sv, exp[31:0], exp[32], exp[33], i >= 50, "w1_rand");
    end
    @(negedge clk);
    set_ready(1, 1'b0);
    for (int i = 0; i < 100; i++) begin
      av = $urandom; bv = $urandom;
      cv = 1'($urandom_range(0, 1)); sv = 1'($urandom_range(0, 1));
      exp = model(32, av, bv, cv, sv);
      do_op(32, av, bv, cv, sv, exp[31:0], exp[32], exp[33], i >= 50, "w32_rand");
    end
    @(negedge clk);
    set_ready(32, 1'b0);
    repeat (2) @(negedge clk);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
